isw_and_driver: RTL and testbench

Upstream sequencing stage for the first-order ISW AND gadget, `isw_and`. It accepts two unmasked 8-bit operands over a valid/ready handshake and splits each into two Boolean shares using an internal PRNG. It also generates the fresh 8-bit randomness R01 and holds all gadget inputs stable for the gadget's full computation window. It then captures the two output shares and presents them downstream over a second valid/ready handshake.

---
 rtl/isw_pkg.sv | 25 ++
 rtl/isw_prng.sv | 35 +++
 rtl/isw_and_driver.sv | 125 ++++++++++++
 tb/tb_isw_and_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/isw_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | isw_pkg : shared widths, PRNG polynomial and driver state encoding |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
package isw_pkg;

  localparam int          ISW_WIDTH = 8;
  localparam logic [31:0] PRNG_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } isw_drv_state_t;

  // One right-shift step of the Galois LFSR x^32+x^22+x^2+x+1.
  function automatic logic [31:0] prng_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? PRNG_POLY : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/isw_prng.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | isw_prng : 32-bit Galois LFSR mask source with seed load           |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module isw_prng
  import isw_pkg::*;
#(
  parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] r_state;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_RST;
    end else if (load) begin
      r_state <= (seed == 32'h0) ? 32'h0000_0001 : seed;
    end else if (step) begin
      r_state <= prng_next(r_state);
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/isw_and_driver.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | isw_and_driver : masks operands, sequences and captures isw_and    |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module isw_and_driver
  import isw_pkg::*;
#(
  parameter int          WIDTH    = ISW_WIDTH,
  parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             seed_we_i,
  input  logic [31:0]      seed_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic [WIDTH-1:0] X0_o,
  output logic [WIDTH-1:0] X1_o,
  output logic [WIDTH-1:0] Y0_o,
  output logic [WIDTH-1:0] Y1_o,
  output logic [WIDTH-1:0] R01_o,
  input  logic [WIDTH-1:0] Q0_i,
  input  logic [WIDTH-1:0] Q1_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] Z0_o,
  output logic [WIDTH-1:0] Z1_o,
  output logic             busy_o
);

  isw_drv_state_t   r_state;
  logic [WIDTH-1:0] r_x0, r_x1, r_y0, r_y1, r_r01, r_z0, r_z1;
  logic             r_out_valid, r_busy;

  logic [31:0]      w_prng_state;
  logic [WIDTH-1:0] w_ma, w_mb, w_r;
  logic             w_idle, w_seed_load, w_accept;
  logic             w_unused_prng;

  assign w_idle      = (r_state == IDLE);
  assign w_seed_load = w_idle & seed_we_i;
  assign in_ready_o  = w_idle & ~seed_we_i;
  assign w_accept    = in_ready_o & in_valid_i;

  isw_prng #(
    .SEED_RST (SEED_RST)
  ) u_prng (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .step  (w_accept),
    .load  (w_seed_load),
    .seed  (seed_i),
    .state (w_prng_state)
  );

  assign w_ma          = w_prng_state[WIDTH-1:0];
  assign w_mb          = w_prng_state[2*WIDTH-1:WIDTH];
  assign w_r           = w_prng_state[3*WIDTH-1:2*WIDTH];
  assign w_unused_prng = ^w_prng_state[31:3*WIDTH];

  // Operands are masked before registering; only shares are ever stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_r01       <= '0;
      r_z0        <= '0;
      r_z1        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x0    <= A_i ^ w_ma;
            r_x1    <= w_ma;
            r_y0    <= B_i ^ w_mb;
            r_y1    <= w_mb;
            r_r01   <= w_r;
            r_busy  <= 1'b1;
            r_state <= S1;
          end
        end
        S1: r_state <= S2;
        S2: r_state <= S3;
        S3: begin
          r_z0        <= Q0_i;
          r_z1        <= Q1_i;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign X0_o        = r_x0;
  assign X1_o        = r_x1;
  assign Y0_o        = r_y0;
  assign Y1_o        = r_y1;
  assign R01_o       = r_r01;
  assign Z0_o        = r_z0;
  assign Z1_o        = r_z1;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_isw_and_driver.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_isw_and_driver : scoreboard bench with a behavioural ISW gadget |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_isw_and_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_we = 1'b0;
  logic [31:0] seed = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_in = '0, b_in = '0;
  logic [7:0]  x0, x1, y0, y1, r01, q0, q1, z0, z1;
  logic        out_valid, out_ready = 1'b1, busy;

  always #5 clk = ~clk;

  isw_and_driver #(.WIDTH(8), .SEED_RST(32'h0000_0001)) dut (
    .clk_i(clk), .rst_ni(rst_n), .seed_we_i(seed_we), .seed_i(seed),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .A_i(a_in), .B_i(b_in),
    .X0_o(x0), .X1_o(x1), .Y0_o(y0), .Y1_o(y1), .R01_o(r01),
    .Q0_i(q0), .Q1_i(q1), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .Z0_o(z0), .Z1_o(z1), .busy_o(busy)
  );

  // Gadget model: tmp sampled one edge after accept, R10 one edge later.
  logic [7:0] g_tmp, g_r10;
  always @(posedge clk) begin
    g_tmp <= (x0 & y1) ^ r01;
    g_r10 <= g_tmp ^ (x1 & y0);
  end
  assign q0 = (x0 & y0) ^ r01;
  assign q1 = (x1 & y1) ^ g_r10;

  int n_checks = 0, n_pass = 0, cyc = 0, n_sent = 0, n_pop = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [7:0] b; } exp_t;
  exp_t sb_q[$];
  exp_t m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        m_e = sb_q.pop_front();
        check("z_and",    {24'h0, z0 ^ z1}, {24'h0, m_e.a & m_e.b});
        check("x_unmask", {24'h0, x0 ^ x1}, {24'h0, m_e.a});
        check("y_unmask", {24'h0, y0 ^ y1}, {24'h0, m_e.b});
        n_pop++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
    bit ok = 1'b0;
    a_in = a; b_in = b; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0; acc_cyc = -1;
      return;
    end
    sb_q.push_back('{a: a, b: b});
    n_sent++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic check_shares(input string tag, input logic [7:0] ex0, ex1, ey0, ey1, er);
    check({tag, "_x0"},  {24'h0, x0},  {24'h0, ex0});
    check({tag, "_x1"},  {24'h0, x1},  {24'h0, ex1});
    check({tag, "_y0"},  {24'h0, y0},  {24'h0, ey0});
    check({tag, "_y1"},  {24'h0, y1},  {24'h0, ey1});
    check({tag, "_r01"}, {24'h0, r01}, {24'h0, er});
  endtask

  initial begin
    int c0, c1, c2, lat;
    logic [7:0] x1a, s_z0, s_z1, s_x0, s_x1, s_y0, s_y1, s_r;
    bit stable, rdy_low, got;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {31'h0, in_ready},  32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_busy",      {31'h0, busy},      32'd0);
    check("rst_shares",    {x0, x1, y0, y1},   32'h0);
    check("rst_r01_z",     {8'h0, r01, z0, z1}, 32'h0);
    @(posedge clk); #1;

    // PRNG state 1: mA=01 mB=00 r=00
    send(8'hF0, 8'h3C, c0);
    check_shares("t1", 8'hF1, 8'h01, 8'h3C, 8'h00, 8'h00);
    check("t1_busy", {31'h0, busy}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1'b1; break; end
    end
    // Accept edge plus three more edges: four edges in total.
    check("t1_latency", got ? cyc - c0 : 32'hFFFF, 32'd3);
    @(posedge clk); #1;

    // States 8020_0003 then C030_0002.
    send(8'hFF, 8'hFF, c1);
    check_shares("t2", 8'hFC, 8'h03, 8'hFF, 8'h00, 8'h20);
    send(8'h00, 8'hA5, c2);
    check_shares("t3", 8'h02, 8'h02, 8'hA5, 8'h00, 8'h30);
    check("b2b_period", c2 - c1, 32'd5);

    send(8'h5A, 8'hC3, c0);
    x1a = x1;
    send(8'h5A, 8'hC3, c1);
    check("x1_fresh", {31'h0, x1a != x1}, 32'd1);

    for (int i = 0; i < 256; i++) begin
      send(i[7:0], 8'((i * 73 + 29) & 8'hFF), c0);
    end
    repeat (6) @(posedge clk); #1;

    out_ready = 1'b0;
    send(8'hC7, 8'h9E, c0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1'b1; break; end
    end
    check("bp_valid", {31'h0, got}, 32'd1);
    s_z0 = z0; s_z1 = z1; s_x0 = x0; s_x1 = x1; s_y0 = y0; s_y1 = y1; s_r = r01;
    stable = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || z0 != s_z0 || z1 != s_z1) stable = 1'b0;
      if (x0 != s_x0 || x1 != s_x1 || y0 != s_y0 || y1 != s_y1 || r01 != s_r) stable = 1'b0;
      if (in_ready) rdy_low = 1'b0;
    end
    check("bp_stable",   {31'h0, stable},  32'd1);
    check("bp_in_ready", {31'h0, rdy_low}, 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    seed_we = 1'b1; seed = 32'h0; in_valid = 1'b1; a_in = 8'h11; b_in = 8'h22;
    @(negedge clk);
    check("seed_in_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk); #1;
    seed_we = 1'b0; in_valid = 1'b0;
    check("seed_no_accept", {31'h0, busy}, 32'd0);
    send(8'h11, 8'h22, c0);
    check_shares("seed", 8'h10, 8'h01, 8'h22, 8'h00, 8'h00);
    repeat (6) @(posedge clk); #1;

    send(8'h6B, 8'hD4, c0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'd0);
    check("arst_busy",      {31'h0, busy},      32'd0);
    check("arst_shares",    {x0, x1, y0, y1},   32'h0);
    check("arst_r01_z",     {8'h0, r01, z0, z1}, 32'h0);
    sb_q.delete();
    n_sent--;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h6B, 8'hD4, c0);
    check_shares("post_rst", 8'h6A, 8'h01, 8'hD4, 8'h00, 8'h00);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_drain", sb_q.size(), 32'd0);
    check("sb_count", n_pop, n_sent);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

endmodule
`default_nettype wire
